// File: rtl/synapse_weight_loader_if.sv
// Bus between the configuration bit source (master) and the weight loader (slave).
//   frame_start  master->slave  start a new frame; this cycle's bit is bit 0 when bit_valid
//   bit_in       master->slave  serial data, MSB of each word first
//   bit_valid    master->slave  bit_in qualifier; low = stall
//   weights_out  slave->master  committed matrix, word k at [TOT-1-k*WIDTH -: WIDTH]
//   load_done    slave->master  one-cycle pulse after weights_out updates
//   busy         slave->master  a frame is in flight
//   word_idx     slave->master  index of the word being shifted
//   err          slave->master  sticky parity error (tied 0 without WLOAD_PARITY_EN)
interface synapse_weight_loader_if #(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 3,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned TOT = N * WIDTH;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

  logic           frame_start;
  logic           bit_in;
  logic           bit_valid;
  logic [TOT-1:0] weights_out;
  logic           load_done;
  logic           busy;
  logic [IW-1:0]  word_idx;
  logic           err;

  modport master (
    output frame_start, bit_in, bit_valid,
    input  weights_out, load_done, busy, word_idx, err
  );

  modport slave (
    input  frame_start, bit_in, bit_valid,
    output weights_out, load_done, busy, word_idx, err
  );
endinterface

// File: rtl/synapse_weight_loader.sv
// Serial-to-parallel loader for the synapse weight matrix. A MSB-first bit stream is assembled
// into ROWS x COLS words of WIDTH bits (row-major) in a shadow buffer; the shadow is copied to
// weights_out only on a full-frame commit, so the neuron side never sees a partial frame.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   wl     synapse_weight_loader_if slave modport (stream in, committed matrix/status out)
// Optional feature: define WLOAD_PARITY_EN to expect one even-parity bit after every word; a
// mismatch sets err, aborts the frame and leaves weights_out untouched.
module synapse_weight_loader #(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 3,
  parameter int unsigned WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  synapse_weight_loader_if.slave wl
);
  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned TOT = N * WIDTH;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
`ifdef WLOAD_PARITY_EN
    StParity = 2'd2,
`endif
    StCommit = 2'd3
  } state_e;

  state_e         r_state,     w_state_nxt;
  logic [TOT-1:0] r_shadow,    w_shadow_nxt;
  logic [TOT-1:0] r_weights,   w_weights_nxt;
  logic           r_load_done, w_load_done_nxt;
  logic [IW-1:0]  r_word_idx,  w_word_idx_nxt;
  logic [BW-1:0]  r_bit_cnt,   w_bit_cnt_nxt;
`ifdef WLOAD_PARITY_EN
  logic           r_err,       w_err_nxt;
`endif

  logic           w_start;
  logic [IW-1:0]  w_idx;
  logic [BW-1:0]  w_cnt;
  int             w_base;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH:0]   w_word_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_shadow    <= '0;
      r_weights   <= '0;
      r_load_done <= 1'b0;
      r_word_idx  <= '0;
      r_bit_cnt   <= '0;
`ifdef WLOAD_PARITY_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_weights   <= w_weights_nxt;
      r_load_done <= w_load_done_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
`ifdef WLOAD_PARITY_EN
      r_err       <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_weights_nxt   = r_weights;
    w_load_done_nxt = 1'b0;
    w_word_idx_nxt  = r_word_idx;
    w_bit_cnt_nxt   = r_bit_cnt;
`ifdef WLOAD_PARITY_EN
    w_err_nxt       = r_err;
`endif

    // frame_start in any state (re)starts at word 0; this cycle's bit already belongs to it
    w_start    = wl.frame_start;
    w_idx      = w_start ? '0 : r_word_idx;
    w_cnt      = w_start ? '0 : r_bit_cnt;
    w_base     = int'(TOT) - 1 - int'(w_idx) * int'(WIDTH);
    w_word     = r_shadow[w_base -: WIDTH];
    w_word_ext = {w_word, wl.bit_in};

    // Commit copies the already-complete shadow, so a new frame may start shifting alongside
    if (r_state == StCommit) begin
      w_weights_nxt   = r_shadow;
      w_load_done_nxt = 1'b1;
      w_state_nxt     = StIdle;
    end

    if (w_start) begin
      w_state_nxt    = StShift;
      w_word_idx_nxt = '0;
      w_bit_cnt_nxt  = '0;
`ifdef WLOAD_PARITY_EN
      w_err_nxt      = 1'b0;
`endif
    end

    if ((w_start || r_state == StShift) && wl.bit_valid) begin
      w_shadow_nxt[w_base -: WIDTH] = w_word_ext[WIDTH-1:0];
      if (w_cnt == BW'(WIDTH - 1)) begin
        w_bit_cnt_nxt  = '0;
        w_word_idx_nxt = w_idx;
`ifdef WLOAD_PARITY_EN
        w_state_nxt    = StParity;
`else
        if (w_idx == IW'(N - 1)) begin
          w_state_nxt = StCommit;
        end else begin
          w_word_idx_nxt = w_idx + 1'b1;
          w_state_nxt    = StShift;
        end
`endif
      end else begin
        w_bit_cnt_nxt = w_cnt + 1'b1;
      end
    end
`ifdef WLOAD_PARITY_EN
    else if (r_state == StParity && wl.bit_valid) begin
      // Even parity: the word XOR its parity bit must be zero
      if ((^w_word) ^ wl.bit_in) begin
        w_err_nxt   = 1'b1;
        w_state_nxt = StIdle;
      end else if (w_idx == IW'(N - 1)) begin
        w_state_nxt = StCommit;
      end else begin
        w_word_idx_nxt = w_idx + 1'b1;
        w_state_nxt    = StShift;
      end
    end
`endif
  end

  assign wl.weights_out = r_weights;
  assign wl.load_done   = r_load_done;
  assign wl.busy        = (r_state != StIdle);
  assign wl.word_idx    = r_word_idx;
`ifdef WLOAD_PARITY_EN
  assign wl.err         = r_err;
`else
  assign wl.err         = 1'b0;
`endif
endmodule

// File: tb/tb_synapse_weight_loader.sv
module tb_synapse_weight_loader;
  localparam int unsigned ROWS  = 5;
  localparam int unsigned COLS  = 3;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned TOT   = N * WIDTH;

  localparam logic [TOT-1:0] F1 = 60'h00F00F00F00F00F;
  localparam logic [TOT-1:0] FA = {N{4'hA}};
  localparam logic [TOT-1:0] FB = {N{4'h5}};
  localparam logic [TOT-1:0] FC = 60'h123456789ABCDEF;
  localparam logic [TOT-1:0] FF = {N{4'hF}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  synapse_weight_loader_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) wl ();
  synapse_weight_loader #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wl    (wl)
  );

  synapse_weight_loader_if #(.ROWS(2), .COLS(2), .WIDTH(8)) sl ();
  synapse_weight_loader #(.ROWS(2), .COLS(2), .WIDTH(8)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .wl    (sl)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int n_load = 0;
  logic [TOT-1:0] exp_q[$];
  logic [TOT-1:0] sb_exp;

  // Scoreboard: every load_done pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (wl.load_done === 1'b1) begin
      n_load++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_load: load_done with weights_out=%h, none expected",
                 wl.weights_out);
      end else begin
        sb_exp = exp_q.pop_front();
        if (wl.weights_out !== sb_exp) begin
          n_err++;
          $display("FAIL sb_weights: got %h, expected %h", wl.weights_out, sb_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic fs, input logic b, input logic v);
    wl.frame_start = fs;
    wl.bit_in      = b;
    wl.bit_valid   = v;
    @(posedge clk);
    #1;
  endtask

  // Stall cycles go before every bit but the first; busy must hold across each of them
  task automatic put_bit(input bit first, input logic b, input int gap);
    if (!first) begin
      for (int g = 0; g < gap; g++) begin
        drive_bit(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (wl.busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_in_stall: got %b, expected 1", wl.busy);
        end
      end
    end
    drive_bit(first, b, 1'b1);
  endtask

  task automatic send_frame(input logic [TOT-1:0] f, input int nbits, input int gap,
                            input int bad_word, input bit push);
    int sent = 0;
    logic [WIDTH-1:0] w;
    if (push) exp_q.push_back(f);
    for (int k = 0; k < int'(N); k++) begin
      w = f[int'(TOT) - 1 - k * int'(WIDTH) -: WIDTH];
      for (int b = 0; b < int'(WIDTH); b++) begin
        if (sent < nbits) begin
          put_bit(sent == 0, w[int'(WIDTH) - 1 - b], gap);
          sent++;
        end
      end
`ifdef WLOAD_PARITY_EN
      if ((k + 1) * int'(WIDTH) < nbits || nbits == int'(TOT))
        put_bit(1'b0, (^w) ^ (k == bad_word), gap);
`endif
    end
    wl.frame_start = 1'b0;
    wl.bit_valid   = 1'b0;
    wl.bit_in      = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (wl.busy === 1'b0 && exp_q.size() == 0) done = 1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b pending=%0d, expected idle with none pending",
               wl.busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    wl.frame_start = 0; wl.bit_in = 0; wl.bit_valid = 0;
    sl.frame_start = 0; sl.bit_in = 0; sl.bit_valid = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec += 5;
    if (wl.weights_out !== '0) begin n_err++; $display("FAIL rst_weights: got %h, expected 0", wl.weights_out); end
    if (wl.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", wl.busy); end
    if (wl.load_done !== 1'b0) begin n_err++; $display("FAIL rst_load_done: got %b, expected 0", wl.load_done); end
    if (wl.word_idx !== '0) begin n_err++; $display("FAIL rst_word_idx: got %0d, expected 0", wl.word_idx); end
    if (wl.err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b, expected 0", wl.err); end
    // Valid bits without frame_start must be ignored
    repeat (3) drive_bit(1'b0, 1'b1, 1'b1);
    wl.bit_valid = 1'b0;
    n_vec++;
    if (wl.busy !== 1'b0) begin n_err++; $display("FAIL idle_ignore: busy got %b, expected 0", wl.busy); end
  endtask

  task automatic test_timing(input int gap, input string tag);
    int l0 = n_load;
    send_frame(F1, TOT, gap, -1, 1'b1);
    @(negedge clk);
    n_vec += 2;
    if (wl.load_done !== 1'b0) begin n_err++; $display("FAIL %s_early_done: got %b, expected 0", tag, wl.load_done); end
    if (wl.busy !== 1'b1) begin n_err++; $display("FAIL %s_commit_busy: got %b, expected 1", tag, wl.busy); end
    @(negedge clk);
    n_vec += 2;
    if (wl.load_done !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b, expected 1", tag, wl.load_done); end
    if (wl.weights_out !== F1) begin n_err++; $display("FAIL %s_weights: got %h, expected %h", tag, wl.weights_out, F1); end
    @(negedge clk);
    n_vec += 3;
    if (wl.load_done !== 1'b0) begin n_err++; $display("FAIL %s_done_pulse: got %b, expected 0", tag, wl.load_done); end
    if (wl.busy !== 1'b0) begin n_err++; $display("FAIL %s_idle_busy: got %b, expected 0", tag, wl.busy); end
    if (n_load !== l0 + 1) begin n_err++; $display("FAIL %s_load_count: got %0d, expected %0d", tag, n_load - l0, 1); end
  endtask

  task automatic test_basic();
    test_timing(0, "basic");
  endtask

  task automatic test_stall();
    test_timing(1, "stall");
  endtask

  task automatic test_abort();
    int exp_idx;
    send_frame(FA, TOT, 0, -1, 1'b1);
    wait_idle();
    send_frame(FB, 20, 0, -1, 1'b0);
`ifdef WLOAD_PARITY_EN
    exp_idx = 4;
`else
    exp_idx = 5;
`endif
    n_vec += 3;
    if (int'(wl.word_idx) !== exp_idx) begin n_err++; $display("FAIL abort_word_idx: got %0d, expected %0d", wl.word_idx, exp_idx); end
    if (wl.weights_out !== FA) begin n_err++; $display("FAIL abort_hold: got %h, expected %h", wl.weights_out, FA); end
    if (wl.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b, expected 1", wl.busy); end
    send_frame(FB, TOT, 0, -1, 1'b1);
    wait_idle();
    n_vec++;
    if (wl.weights_out !== FB) begin n_err++; $display("FAIL abort_final: got %h, expected %h", wl.weights_out, FB); end
  endtask

  task automatic test_reset_mid();
    send_frame(FA, 30, 0, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec += 3;
    if (wl.weights_out !== '0) begin n_err++; $display("FAIL rstmid_weights: got %h, expected 0", wl.weights_out); end
    if (wl.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, expected 0", wl.busy); end
    if (wl.word_idx !== '0) begin n_err++; $display("FAIL rstmid_word_idx: got %0d, expected 0", wl.word_idx); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(FA, TOT, 0, -1, 1'b1);
    wait_idle();
    n_vec++;
    if (wl.weights_out !== FA) begin n_err++; $display("FAIL rstmid_reload: got %h, expected %h", wl.weights_out, FA); end
  endtask

  task automatic test_back_to_back();
    int l0 = n_load;
    send_frame(FC, TOT, 0, -1, 1'b1);
    send_frame(~FC, TOT, 0, -1, 1'b1);
    wait_idle();
    n_vec += 2;
    if (n_load !== l0 + 2) begin n_err++; $display("FAIL b2b_loads: got %0d, expected 2", n_load - l0); end
    if (wl.weights_out !== ~FC) begin n_err++; $display("FAIL b2b_final: got %h, expected %h", wl.weights_out, ~FC); end
  endtask

  task automatic test_small();
    logic [31:0] f = 32'h12345678;
    logic [7:0]  w;
    bit seen = 0;
    for (int k = 0; k < 4; k++) begin
      w = f[31 - 8 * k -: 8];
      for (int b = 0; b < 8; b++) begin
        sl.frame_start = (k == 0 && b == 0);
        sl.bit_in      = w[7 - b];
        sl.bit_valid   = 1'b1;
        @(posedge clk); #1;
      end
`ifdef WLOAD_PARITY_EN
      sl.frame_start = 1'b0; sl.bit_in = ^w; sl.bit_valid = 1'b1;
      @(posedge clk); #1;
`endif
    end
    sl.frame_start = 1'b0; sl.bit_valid = 1'b0; sl.bit_in = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (sl.load_done === 1'b1) seen = 1;
    end
    n_vec += 2;
    if (!seen) begin n_err++; $display("FAIL small_done: no load_done within 10 cycles, expected one"); end
    if (sl.weights_out !== 32'h12345678) begin n_err++; $display("FAIL small_weights: got %h, expected 12345678", sl.weights_out); end
  endtask

  task automatic test_parity();
`ifdef WLOAD_PARITY_EN
    int l0 = n_load;
    logic [TOT-1:0] prev = wl.weights_out;
    send_frame(FF, TOT, 0, 3, 1'b0);
    repeat (3) @(negedge clk);
    n_vec += 4;
    if (wl.err !== 1'b1) begin n_err++; $display("FAIL par_err: got %b, expected 1", wl.err); end
    if (wl.busy !== 1'b0) begin n_err++; $display("FAIL par_busy: got %b, expected 0", wl.busy); end
    if (n_load !== l0) begin n_err++; $display("FAIL par_no_load: got %0d loads, expected 0", n_load - l0); end
    if (wl.weights_out !== prev) begin n_err++; $display("FAIL par_hold: got %h, expected %h", wl.weights_out, prev); end
    send_frame(FF, TOT, 0, -1, 1'b1);
    wait_idle();
    n_vec += 2;
    if (wl.err !== 1'b0) begin n_err++; $display("FAIL par_clear: got %b, expected 0", wl.err); end
    if (wl.weights_out !== FF) begin n_err++; $display("FAIL par_reload: got %h, expected %h", wl.weights_out, FF); end
`else
    n_vec++;
    if (wl.err !== 1'b0) begin n_err++; $display("FAIL err_tied: got %b, expected 0", wl.err); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_small();
    test_parity();
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d frames never loaded, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
